// File: rtl/mult_seq_arbiter_pkg.sv
// Shared definitions for the round-robin multiply sequencer: FSM encoding,
// digit width and derived-size helpers.
package mult_seq_arbiter_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic int calc_d(input int data_width);
    return data_width / DIGIT_W;
  endfunction

  function automatic int calc_idw(input int n_req);
    return (n_req <= 1) ? 1 : $clog2(n_req);
  endfunction

  // Width of the partial-product step counter (D*D steps).
  function automatic int calc_kw(input int d);
    return (d * d <= 1) ? 1 : $clog2(d * d);
  endfunction

endpackage

// File: rtl/mult_seq_arbiter_if.sv
// Request/response bus between client datapaths and the shared multiplier
// sequencer; the slave modport is the sequencer side.
interface mult_seq_arbiter_if
  import mult_seq_arbiter_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 8
);

  localparam int IDW = calc_idw(N_REQ);

  // A transfer happens on a rising edge where valid and ready are both high.
  // Request side: io_req_ready may depend combinationally on io_req_valid;
  // response side: valid/data/id are held until io_resp_ready is seen.
  logic [N_REQ-1:0]            io_req_valid;
  logic [N_REQ-1:0]            io_req_ready;
  logic [N_REQ*DATA_WIDTH-1:0] io_req_lhs;
  logic [N_REQ*DATA_WIDTH-1:0] io_req_rhs;
  logic                        io_resp_valid;
  logic                        io_resp_ready;
  logic [2*DATA_WIDTH-1:0]     io_resp_data;
  logic [IDW-1:0]              io_resp_id;
  logic                        io_busy;
  state_e                      dbg_state;

  modport master (
    output io_req_valid, io_req_lhs, io_req_rhs, io_resp_ready,
    input  io_req_ready, io_resp_valid, io_resp_data, io_resp_id, io_busy,
    input  dbg_state
  );

  modport slave (
    input  io_req_valid, io_req_lhs, io_req_rhs, io_resp_ready,
    output io_req_ready, io_resp_valid, io_resp_data, io_resp_id, io_busy,
    output dbg_state
  );

endinterface

// File: rtl/mult_seq_arbiter_lut.sv
// 4x4 -> 8-bit unsigned product table, 256 entries indexed {a, b}.
module mult4_lut
  import mult_seq_arbiter_pkg::*;
(
  input  logic [DIGIT_W-1:0]   a_i,
  input  logic [DIGIT_W-1:0]   b_i,
  output logic [2*DIGIT_W-1:0] p_o
);

  logic [2*DIGIT_W-1:0] rom [256];

  always_comb begin
    for (int n = 0; n < 256; n++) begin
      rom[n] = 8'(n / 16) * 8'(n % 16);
    end
  end

  assign p_o = rom[{a_i, b_i}];

endmodule

// File: rtl/mult_seq_arbiter.sv
// Round-robin front end that feeds one shared 4x4 table multiplier, building a
// DATA_WIDTH x DATA_WIDTH product digit by digit and returning it with its id.
module mult_seq_arbiter
  import mult_seq_arbiter_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int DATA_WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  mult_seq_arbiter_if.slave bus
);

  localparam int D   = calc_d(DATA_WIDTH);
  localparam int IDW = calc_idw(N_REQ);
  localparam int KW  = calc_kw(D);
  localparam int PW  = 2 * DATA_WIDTH;
  localparam logic [KW-1:0] K_LAST = KW'(D * D - 1);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   lhs_q, lhs_d;
  logic [DATA_WIDTH-1:0]   rhs_q, rhs_d;
  logic [PW-1:0]           acc_q, acc_d;
  logic [KW-1:0]           k_q, k_d;
  logic [IDW-1:0]          id_q, id_d;
  logic [IDW-1:0]          last_q, last_d;

  logic [IDW-1:0]          win;
  logic                    win_vld;
  logic [N_REQ-1:0]        grant;
  logic [DIGIT_W-1:0]      dig_a, dig_b;
  logic [2*DIGIT_W-1:0]    pp;
  logic [PW-1:0]           pp_shift;

  // Scan from the farthest offset down so the nearest requester after
  // last_q is the one left in win.
  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = (int'(last_q) + off) % N_REQ;
      if (bus.io_req_valid[idx]) begin
        win     = IDW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    if (state_q == ST_IDLE && win_vld && !reset) begin
      grant[win] = 1'b1;
    end
  end

  always_comb begin
    int di;
    int dj;
    di       = int'(k_q) / D;
    dj       = int'(k_q) % D;
    dig_a    = lhs_q[di*DIGIT_W +: DIGIT_W];
    dig_b    = rhs_q[dj*DIGIT_W +: DIGIT_W];
    pp_shift = PW'(pp) << (DIGIT_W * (di + dj));
  end

  mult4_lut u_lut (
    .a_i (dig_a),
    .b_i (dig_b),
    .p_o (pp)
  );

  always_comb begin
    state_d = state_q;
    lhs_d   = lhs_q;
    rhs_d   = rhs_q;
    acc_d   = acc_q;
    k_d     = k_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          state_d = ST_CALC;
          lhs_d   = bus.io_req_lhs[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          rhs_d   = bus.io_req_rhs[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          id_d    = win;
          last_d  = win;
          acc_d   = '0;
          k_d     = '0;
        end
      end
      ST_CALC: begin
        acc_d = acc_q + pp_shift;
        k_d   = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.io_resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lhs_q   <= '0;
      rhs_q   <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      id_q    <= '0;
      last_q  <= IDW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      lhs_q   <= lhs_d;
      rhs_q   <= rhs_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign bus.io_req_ready  = grant;
  assign bus.io_resp_valid = (state_q == ST_RESP);
  assign bus.io_resp_data  = acc_q;
  assign bus.io_resp_id    = id_q;
  assign bus.io_busy       = (state_q != ST_IDLE);
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_mult_seq_arbiter.sv
// Bench for mult_seq_arbiter: directed literal cases plus random traffic
// checked every cycle against a transaction-level model.
module tb_mult_seq_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int D  = DW / 4;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mult_seq_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();
  mult_seq_arbiter_if #(.N_REQ(1), .DATA_WIDTH(12)) bus12 ();

  mult_seq_arbiter #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mult_seq_arbiter #(.N_REQ(1), .DATA_WIDTH(12)) dut12 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus12)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: idle -> busy for D*D cycles with the product already
  // known -> response held until accepted.
  int               m_st   = 0;
  int               m_cnt  = 0;
  int               m_last = N - 1;
  int               m_id   = 0;
  logic [2*DW-1:0]  m_data = '0;

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int off = 1; off <= N; off++) begin
      if (v[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st   <= 0;
      m_last <= N - 1;
      m_id   <= 0;
      m_data <= '0;
      m_cnt  <= 0;
    end else begin
      case (m_st)
        0: begin
          if (rr_pick(bus.io_req_valid, m_last) >= 0) begin
            m_last <= rr_pick(bus.io_req_valid, m_last);
            m_id   <= rr_pick(bus.io_req_valid, m_last);
            m_data <= {8'h00, bus.io_req_lhs[rr_pick(bus.io_req_valid, m_last)*DW +: DW]} *
                      {8'h00, bus.io_req_rhs[rr_pick(bus.io_req_valid, m_last)*DW +: DW]};
            m_cnt  <= D * D;
            m_st   <= 1;
          end
        end
        1: begin
          m_cnt <= m_cnt - 1;
          if (m_cnt == 1) m_st <= 2;
        end
        default: begin
          if (bus.io_resp_ready) m_st <= 0;
        end
      endcase
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin : cmp
    logic [N-1:0] exp_ready;
    int           g;
    #1;
    exp_ready = '0;
    if (m_st == 0 && !reset) begin
      g = rr_pick(bus.io_req_valid, m_last);
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    check("req_ready", 64'(bus.io_req_ready), 64'(exp_ready));
    check("busy", 64'(bus.io_busy), 64'(m_st != 0));
    check("resp_valid", 64'(bus.io_resp_valid), 64'(m_st == 2));
    if (m_st == 2) begin
      check("resp_data", 64'(bus.io_resp_data), 64'(m_data));
      check("resp_id", 64'(bus.io_resp_id), 64'(m_id));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_resp(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!bus.io_resp_valid && cyc < 20);
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 idle.
  task automatic run_one(input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_d);
    int cyc;
    bus.io_req_valid           = '0;
    bus.io_req_valid[r]        = 1'b1;
    bus.io_req_lhs[r*DW +: DW] = a;
    bus.io_req_rhs[r*DW +: DW] = b;
    bus.io_resp_ready          = 1'b1;
    #1;
    check("ready_same_cycle", 64'(bus.io_req_ready), 64'(1) << r);
    @(posedge clk); #1;
    bus.io_req_valid = '0;
    wait_resp(cyc);
    check("latency", 64'(cyc), 64'(4));
    check("one_data", 64'(bus.io_resp_data), 64'(exp_d));
    check("one_id", 64'(bus.io_resp_id), 64'(r));
    @(posedge clk); #1;
  endtask

  task automatic fairness();
    int cyc;
    bus.io_req_valid  = 2'b11;
    bus.io_req_lhs    = {8'h56, 8'h12};
    bus.io_req_rhs    = {8'h78, 8'h34};
    bus.io_resp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      cyc = 0;
      while (!bus.io_resp_valid && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("fair_id", 64'(bus.io_resp_id), 64'(n % 2));
      check("fair_data", 64'(bus.io_resp_data), (n % 2 == 0) ? 64'h03A8 : 64'h2850);
      @(posedge clk); #1;
    end
    bus.io_req_valid = '0;
  endtask

  task automatic backpressure();
    int cyc;
    bus.io_resp_ready = 1'b0;
    bus.io_req_valid  = 2'b01;
    bus.io_req_lhs    = {8'h00, 8'h9A};
    bus.io_req_rhs    = {8'h00, 8'h3C};
    @(posedge clk); #1;
    bus.io_req_valid = 2'b10;
    bus.io_req_lhs   = {8'h21, 8'hEE};
    bus.io_req_rhs   = {8'h07, 8'hEE};
    wait_resp(cyc);
    check("bp_data", 64'(bus.io_resp_data), 64'h2418);
    check("bp_id", 64'(bus.io_resp_id), 64'(0));
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(bus.io_resp_valid), 64'(1));
      check("hold_data", 64'(bus.io_resp_data), 64'h2418);
      check("hold_id", 64'(bus.io_resp_id), 64'(0));
      check("hold_ready", 64'(bus.io_req_ready), 64'(0));
    end
    bus.io_resp_ready = 1'b1;
    @(posedge clk); #1;
    check("next_accept_ready", 64'(bus.io_req_ready), 64'b10);
    @(posedge clk); #1;
    bus.io_req_valid = '0;
    wait_resp(cyc);
    check("bp2_latency", 64'(cyc), 64'(4));
    check("bp2_data", 64'(bus.io_resp_data), 64'h00E7);
    check("bp2_id", 64'(bus.io_resp_id), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_calc();
    bus.io_resp_ready = 1'b1;
    bus.io_req_valid  = 2'b01;
    bus.io_req_lhs    = {8'h10, 8'h55};
    bus.io_req_rhs    = {8'h10, 8'h55};
    @(posedge clk); #1;
    bus.io_req_valid = 2'b10;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("rst_valid", 64'(bus.io_resp_valid), 64'(0));
    check("rst_data", 64'(bus.io_resp_data), 64'(0));
    check("rst_id", 64'(bus.io_resp_id), 64'(0));
    check("rst_busy", 64'(bus.io_busy), 64'(0));
    check("rst_ready", 64'(bus.io_req_ready), 64'(0));
    @(posedge clk); #1;
    bus.io_req_valid = '0;
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      check("no_stale_resp", 64'(bus.io_resp_valid), 64'(0));
    end
  endtask

  task automatic width12();
    int cyc;
    bus12.io_req_valid  = 1'b1;
    bus12.io_req_lhs    = 12'hFFF;
    bus12.io_req_rhs    = 12'hFFF;
    bus12.io_resp_ready = 1'b1;
    #1;
    check("w12_ready", 64'(bus12.io_req_ready), 64'(1));
    @(posedge clk); #1;
    bus12.io_req_valid = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!bus12.io_resp_valid && cyc < 30);
    check("w12_latency", 64'(cyc), 64'(9));
    check("w12_data", 64'(bus12.io_resp_data), 64'hFFE001);
    check("w12_id", 64'(bus12.io_resp_id), 64'(0));
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset               = 1'b1;
    bus.io_req_valid    = '0;
    bus.io_req_lhs      = '0;
    bus.io_req_rhs      = '0;
    bus.io_resp_ready   = 1'b1;
    bus12.io_req_valid  = '0;
    bus12.io_req_lhs    = '0;
    bus12.io_req_rhs    = '0;
    bus12.io_resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(bus.io_resp_valid), 64'(0));
    check("reset_data", 64'(bus.io_resp_data), 64'(0));
    check("reset_id", 64'(bus.io_resp_id), 64'(0));
    check("reset_busy", 64'(bus.io_busy), 64'(0));
    bus.io_req_valid = 2'b11;
    #1;
    check("reset_ready_gated", 64'(bus.io_req_ready), 64'(0));
    bus.io_req_valid = '0;
    reset = 1'b0;
    @(posedge clk); #1;

    run_one(0, 8'h0F, 8'h0F, 16'h00E1);
    run_one(0, 8'hFF, 8'hFF, 16'hFE01);
    run_one(1, 8'h00, 8'hAB, 16'h0000);
    fairness();
    backpressure();
    reset_mid_calc();
    run_one(1, 8'h10, 8'h10, 16'h0100);

    repeat (400) begin
      bus.io_req_valid  = N'($urandom_range(0, 3));
      bus.io_req_lhs    = 16'($urandom);
      bus.io_req_rhs    = 16'($urandom);
      bus.io_resp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 149) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        reset = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.io_req_valid  = '0;
    bus.io_resp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    width12();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
